dma_xfer_engine: RTL and testbench

//  Data-mover stage directly downstream of the DMA controller. Watches the controller's valid flags;

---
 rtl/dma_xfer_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_dma_xfer_engine.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: copies length_i+1 words from src to dst over a single
// OBI-style port. Words are staged in a small FIFO, so the transfer runs as
// alternating read and write bursts. Only one transaction is outstanding at
// a time.
module dma_xfer_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] valid_i,
  input  logic [DATA_WIDTH-1:0] length_i,
  input  logic [DATA_WIDTH-1:0] src_lsb_i,
  input  logic [DATA_WIDTH-1:0] src_msb_i,
  input  logic [DATA_WIDTH-1:0] dst_lsb_i,
  input  logic [DATA_WIDTH-1:0] dst_msb_i,
  output logic [DATA_WIDTH-1:0] done_o,
  output logic                  xfer_err_o,
  output logic [DATA_WIDTH:0]   words_done_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [63:0]           mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = DATA_WIDTH + 1;
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FINISH
  } state_e;

  state_e state_q, state_d;

  logic             start_prev_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [63:0]      src_base_q;
  logic [63:0]      dst_base_q;
  logic             xfer_err_q;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      fifo_wptr_q;
  logic [PTR_W-1:0]      fifo_rptr_q;
  logic [PTR_W:0]        fifo_cnt_q;

  logic             start;
  logic             permit;
  logic             push;
  logic             pop;
  logic             rd_inc;
  logic             wr_inc;
  logic             set_err;
  logic             fifo_clr;
  logic [CNT_W-1:0] rd_cnt_inc;
  logic [CNT_W-1:0] wr_cnt_inc;
  logic [PTR_W:0]   fifo_cnt_inc;
  logic [63:0]      rd_addr;
  logic [63:0]      wr_addr;

  // Flag bits and low address bits that the engine deliberately ignores.
  logic unused_bits;
  assign unused_bits = ^{valid_i[DATA_WIDTH-1:4], valid_i[0],
                         src_lsb_i[2:0], dst_lsb_i[2:0]};

  // A transfer starts only on a 0->1 transition of DONE seen while idle.
  assign start  = (state_q == IDLE) && valid_i[3] && !start_prev_q;
  assign permit = valid_i[1] && valid_i[2];

  assign rd_cnt_inc   = rd_cnt_q + CNT_W'(1);
  assign wr_cnt_inc   = wr_cnt_q + CNT_W'(1);
  assign fifo_cnt_inc = fifo_cnt_q + (PTR_W+1)'(1);
  assign rd_addr      = src_base_q + 64'({rd_cnt_q, 2'b00});
  assign wr_addr      = dst_base_q + 64'({wr_cnt_q, 2'b00});

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise paths
    // that do not assign it would infer a latch.
    state_d  = state_q;
    push     = 1'b0;
    pop      = 1'b0;
    rd_inc   = 1'b0;
    wr_inc   = 1'b0;
    set_err  = 1'b0;
    fifo_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = permit ? RD_REQ : FINISH;
      end
      RD_REQ: begin
        if (mem_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          if (mem_err_i) begin
            set_err = 1'b1;
            state_d = FINISH;
          end else begin
            push   = 1'b1;
            rd_inc = 1'b1;
            if (rd_cnt_inc < total_q && fifo_cnt_inc < FIFO_FULL) state_d = RD_REQ;
            else                                                   state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (mem_gnt_i) begin
          pop     = 1'b1;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (mem_rvalid_i) begin
          if (mem_err_i) begin
            set_err = 1'b1;
            state_d = FINISH;
          end else begin
            wr_inc = 1'b1;
            if (wr_cnt_inc == total_q)            state_d = FINISH;
            else if (fifo_cnt_q != '0)            state_d = WR_REQ;
            else                                  state_d = RD_REQ;
          end
        end
      end
      FINISH: begin
        if (!valid_i[3]) begin
          state_d  = IDLE;
          fifo_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer bookkeeping: start detect, latched bases/length, counters, error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_prev_q <= 1'b0;
      total_q      <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      xfer_err_q   <= 1'b0;
    end else begin
      start_prev_q <= valid_i[3];
      if (start) begin
        total_q    <= {1'b0, length_i} + CNT_W'(1);
        src_base_q <= 64'({src_msb_i, src_lsb_i[DATA_WIDTH-1:3], 3'b000});
        dst_base_q <= 64'({dst_msb_i, dst_lsb_i[DATA_WIDTH-1:3], 3'b000});
        rd_cnt_q   <= '0;
        wr_cnt_q   <= '0;
        xfer_err_q <= !permit;
      end else begin
        if (set_err) xfer_err_q <= 1'b1;
        if (rd_inc)  rd_cnt_q   <= rd_cnt_inc;
        if (wr_inc)  wr_cnt_q   <= wr_cnt_inc;
      end
    end
  end

  // FIFO pointers and occupancy; contents are dropped when a transfer closes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else if (fifo_clr) begin
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else if (push) begin
      fifo_wptr_q <= fifo_wptr_q + PTR_W'(1);
      fifo_cnt_q  <= fifo_cnt_inc;
    end else if (pop) begin
      fifo_rptr_q <= fifo_rptr_q + PTR_W'(1);
      fifo_cnt_q  <= fifo_cnt_q - (PTR_W+1)'(1);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers, so stale words are never read and need no clearing.
    if (push) fifo_mem[fifo_wptr_q] <= mem_rdata_i;
  end

  // Memory request outputs, driven only in the request states.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == RD_REQ) begin
      mem_req_o  = 1'b1;
      mem_addr_o = rd_addr;
    end else if (state_q == WR_REQ) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = wr_addr;
      mem_wdata_o = fifo_mem[fifo_rptr_q];
    end
  end

  assign mem_be_o     = 4'hF;
  assign done_o       = DATA_WIDTH'(state_q == FINISH);
  assign xfer_err_o   = xfer_err_q;
  assign words_done_o = wr_cnt_q;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Bench for dma_xfer_engine: a behavioural memory slave answers the engine
// and logs every accepted request; directed transfers are then compared
// against hand-built expected request sequences.
module tb_dma_xfer_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] valid_i, length_i, src_lsb_i, src_msb_i, dst_lsb_i, dst_msb_i;
  logic [31:0] done_o;
  logic        xfer_err_o;
  logic [32:0] words_done_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [63:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration (written by the test only).
  int          err_rd_idx  = -1;
  int          stall_wr_idx = -1;

  // Slave state and logs (written by the slave only).
  int          rd_resp_idx = 0;
  int          wr_gnt_idx  = 0;
  int          stall_cnt   = 0;
  logic        pend        = 1'b0;
  logic        pend_we     = 1'b0;
  logic [63:0] pend_addr   = '0;
  logic        log_we   [$];
  logic [63:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        st_we    [$];
  logic [63:0] st_addr  [$];
  logic [31:0] st_data  [$];
  logic [3:0]  st_be    [$];

  // Expected request sequence for the current transfer.
  logic        exp_we   [$];
  logic [63:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int          log_base;

  dma_xfer_engine #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid_i),
    .length_i     (length_i),
    .src_lsb_i    (src_lsb_i),
    .src_msb_i    (src_msb_i),
    .dst_lsb_i    (dst_lsb_i),
    .dst_msb_i    (dst_msb_i),
    .done_o       (done_o),
    .xfer_err_o   (xfer_err_o),
    .words_done_o (words_done_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  always #5 clk = ~clk;

  // Source memory contents: unique per address.
  function automatic logic [31:0] src_word(input logic [63:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory slave: decides gnt/rvalid on the falling edge for the next rising
  // edge. Response comes the cycle after the grant.
  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    if (pend) begin
      mem_rvalid_i = 1'b1;
      if (!pend_we) begin
        mem_rdata_i = src_word(pend_addr);
        mem_err_i   = (rd_resp_idx == err_rd_idx);
        rd_resp_idx++;
      end
      pend = 1'b0;
    end else if (mem_req_o === 1'b1) begin
      if (stall_cnt > 0) begin
        st_we.push_back(mem_we_o);
        st_addr.push_back(mem_addr_o);
        st_data.push_back(mem_wdata_o);
        st_be.push_back(mem_be_o);
      end
      if ((stall_cnt == 0 && mem_we_o && wr_gnt_idx == stall_wr_idx) ||
          (stall_cnt > 0 && stall_cnt < 5)) begin
        stall_cnt++;
      end else begin
        stall_cnt = 0;
        mem_gnt_i = 1'b1;
        pend      = 1'b1;
        pend_we   = mem_we_o;
        pend_addr = mem_addr_o;
        log_we.push_back(mem_we_o);
        log_addr.push_back(mem_addr_o);
        log_data.push_back(mem_wdata_o);
        if (mem_we_o) wr_gnt_idx++;
      end
    end
  end

  task automatic new_xfer();
    log_base = log_addr.size();
    exp_we.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic exp_rd(input logic [63:0] a);
    exp_we.push_back(1'b0);
    exp_addr.push_back(a);
    exp_data.push_back(32'h0);
  endtask

  task automatic exp_wr(input logic [63:0] a, input logic [31:0] d);
    exp_we.push_back(1'b1);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic compare_log(input string tag);
    int n;
    n = log_addr.size() - log_base;
    check({tag, " req count"}, 64'(n), 64'(exp_addr.size()));
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      check($sformatf("%s[%0d] we", tag, i), 64'(log_we[log_base+i]), 64'(exp_we[i]));
      check($sformatf("%s[%0d] addr", tag, i), log_addr[log_base+i], exp_addr[i]);
      if (exp_we[i])
        check($sformatf("%s[%0d] data", tag, i), 64'(log_data[log_base+i]), 64'(exp_data[i]));
    end
  endtask

  task automatic start_xfer(input logic [31:0] len, input logic [31:0] src,
                            input logic [31:0] dst, input logic [31:0] vld);
    @(negedge clk); #1;
    length_i  = len;
    src_lsb_i = src;
    src_msb_i = 32'h0;
    dst_lsb_i = dst;
    dst_msb_i = 32'h0;
    valid_i   = vld;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_o[0] !== 1'b1 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, " done_o"}, 64'(done_o), 64'h1);
  endtask

  task automatic end_xfer(input string tag);
    valid_i = 32'h0;
    @(negedge clk); #1;
    check({tag, " done_o cleared"}, 64'(done_o), 64'h0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " done_o"},       64'(done_o),       64'h0);
    check({tag, " xfer_err_o"},   64'(xfer_err_o),   64'h0);
    check({tag, " words_done_o"}, 64'(words_done_o), 64'h0);
    check({tag, " mem_req_o"},    64'(mem_req_o),    64'h0);
    check({tag, " mem_we_o"},     64'(mem_we_o),     64'h0);
    check({tag, " mem_addr_o"},   mem_addr_o,        64'h0);
    check({tag, " mem_wdata_o"},  64'(mem_wdata_o),  64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sz [3] = '{8, 8, 4};
    int ri, wi, n, wr_base;

    rst_n     = 1'b0;
    valid_i   = 32'h0;
    length_i  = 32'h0;
    src_lsb_i = 32'h0;
    src_msb_i = 32'h0;
    dst_lsb_i = 32'h0;
    dst_msb_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Short copy: 4 reads then 4 writes.
    new_xfer();
    for (int i = 0; i < 4; i++) exp_rd(64'h1000 + 64'(4*i));
    for (int i = 0; i < 4; i++) exp_wr(64'h2000 + 64'(4*i), src_word(64'h1000 + 64'(4*i)));
    start_xfer(32'd3, 32'h1000, 32'h2000, 32'hE);
    wait_done("t1");
    compare_log("t1");
    check("t1 words_done_o", 64'(words_done_o), 64'd4);
    check("t1 xfer_err_o", 64'(xfer_err_o), 64'h0);
    end_xfer("t1");

    // 20 words through an 8-deep FIFO: bursts 8/8, 8/8, 4/4.
    new_xfer();
    ri = 0;
    wi = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < sz[p]; k++) begin
        exp_rd(64'h4000 + 64'(4*ri));
        ri++;
      end
      for (int k = 0; k < sz[p]; k++) begin
        exp_wr(64'h8000 + 64'(4*wi), src_word(64'h4000 + 64'(4*wi)));
        wi++;
      end
    end
    start_xfer(32'd19, 32'h4000, 32'h8000, 32'hE);
    wait_done("t2");
    compare_log("t2");
    check("t2 words_done_o", 64'(words_done_o), 64'd20);
    end_xfer("t2");

    // Store not permitted: no traffic, immediate error completion.
    new_xfer();
    start_xfer(32'd3, 32'h1000, 32'h2000, 32'h8);
    check("t3 done_o before edge", 64'(done_o), 64'h0);
    @(negedge clk); #1;
    check("t3 done_o", 64'(done_o), 64'h1);
    check("t3 xfer_err_o", 64'(xfer_err_o), 64'h1);
    check("t3 mem_req_o", 64'(mem_req_o), 64'h0);
    repeat (3) @(negedge clk);
    #1;
    compare_log("t3");
    end_xfer("t3");
    check("t3 xfer_err_o sticky", 64'(xfer_err_o), 64'h1);

    // Bus error on the third read response aborts the transfer.
    new_xfer();
    err_rd_idx = rd_resp_idx + 2;
    for (int i = 0; i < 3; i++) exp_rd(64'h5000 + 64'(4*i));
    start_xfer(32'd7, 32'h5000, 32'h6000, 32'hE);
    wait_done("t4");
    repeat (5) @(negedge clk);
    #1;
    compare_log("t4");
    check("t4 xfer_err_o", 64'(xfer_err_o), 64'h1);
    check("t4 words_done_o", 64'(words_done_o), 64'd0);
    check("t4 mem_req_o", 64'(mem_req_o), 64'h0);
    check("t4 done_o held", 64'(done_o), 64'h1);
    err_rd_idx = -1;
    end_xfer("t4");

    // Unaligned source base, first write grant withheld for 5 cycles.
    new_xfer();
    stall_wr_idx = wr_gnt_idx;
    n = st_addr.size();
    exp_rd(64'h1000);
    exp_rd(64'h1004);
    exp_wr(64'h3000, src_word(64'h1000));
    exp_wr(64'h3004, src_word(64'h1004));
    start_xfer(32'd1, 32'h1004, 32'h3000, 32'hE);
    wait_done("t5");
    compare_log("t5");
    check("t5 xfer_err_o cleared", 64'(xfer_err_o), 64'h0);
    check("t5 stall samples", 64'(st_addr.size() - n), 64'd5);
    for (int i = n; i < st_addr.size(); i++) begin
      check($sformatf("t5 stall%0d we", i - n),    64'(st_we[i]),   64'h1);
      check($sformatf("t5 stall%0d addr", i - n),  st_addr[i],      64'h3000);
      check($sformatf("t5 stall%0d wdata", i - n), 64'(st_data[i]), 64'(src_word(64'h1000)));
      check($sformatf("t5 stall%0d be", i - n),    64'(st_be[i]),   64'hF);
    end
    stall_wr_idx = -1;
    end_xfer("t5");

    // Reset while waiting for the first write ack; the late ack is ignored.
    new_xfer();
    wr_base = wr_gnt_idx;
    start_xfer(32'd3, 32'h1000, 32'h2000, 32'hE);
    n = 0;
    while (wr_gnt_idx == wr_base && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6 write granted", 64'(wr_gnt_idx - wr_base), 64'd1);
    @(posedge clk); #2;
    rst_n   = 1'b0;
    valid_i = 32'h0;
    #1;
    check_idle_outputs("t6 in reset");
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("t6 after late ack");

    new_xfer();
    for (int i = 0; i < 4; i++) exp_rd(64'h1000 + 64'(4*i));
    for (int i = 0; i < 4; i++) exp_wr(64'h2000 + 64'(4*i), src_word(64'h1000 + 64'(4*i)));
    start_xfer(32'd3, 32'h1000, 32'h2000, 32'hE);
    wait_done("t6b");
    compare_log("t6b");
    check("t6b words_done_o", 64'(words_done_o), 64'd4);
    end_xfer("t6b");

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
